fp_memory_examiner: RTL and testbench
=====================================

Name: fp_memory_examiner

Overview:
- Synthesizable sequencer that reads PDP-8 memory back out through the Front_Panel. It is the read-back counterpart of the Load_PC/Deposit loader.
- It drives the panel switches plus the load-PC and examine buttons, and captures the examined word from the panel data display.
- It streams address/data pairs to the host side over a valid/ready handshake.
- Used after a program halts, to dump memory for checking against the expected image.

Parameters:
- SETUP_CYCLES, 10, clocks sw is stable before a button press; also the post-release gap after load-PC.
- HOLD_CYCLES, 10, clocks each button is held high.
- SETTLE_CYCLES, 30, clocks after examine release before fp_data is sampled.

Ports:
- clk  input  1  system clock; all logic on posedge.
- rst  input  1  reset, asynchronous, active-high.
- start  input  1  one-cycle request to begin a dump; ignored while busy=1.
- start_addr  input  12  first address; sampled when start is accepted.
- end_addr  input  12  last address, inclusive; sampled when start is accepted.
- busy  output  1  high from the cycle after start is accepted until done.
- done  output  1  one-cycle pulse after the last word handshakes.
- sw  output  12  front panel switch register value.
- load_pc_btn  output  1  front panel load-PC button.
- examine_btn  output  1  front panel examine button; the panel loads MB from memory[PC] and increments PC.
- fp_data  input  12  word displayed by the panel after examine.
- word_valid  output  1  word_addr/word_data are valid.
- word_ready  input  1  host accepts the word.
- word_addr  output  12  address of the dumped word.
- word_data  output  12  data of the dumped word.

Behaviour:
- Reset values: busy=0, done=0, sw=0, load_pc_btn=0, examine_btn=0, word_valid=0, word_addr=0, word_data=0, state=IDLE, counters=0.
- Reset asserted mid-operation aborts immediately. Buttons are released in the same cycle (asynchronous), no partial word is emitted and no done pulse is produced.
- Registers: addr, last (latched end_addr), cycle counter. Width is 16 bits, which is sufficient for all parameters ≤ 65535.
- IDLE:
  - start=1 latches addr=start_addr, last=end_addr and sets sw=start_addr; go to LPC_SETUP.
  - busy=1 from the next cycle.
- LPC_SETUP: hold sw for SETUP_CYCLES clocks, then go to LPC_PRESS.
- LPC_PRESS: load_pc_btn=1 for exactly HOLD_CYCLES clocks, then go to LPC_GAP.
- LPC_GAP: load_pc_btn=0 for SETUP_CYCLES clocks, then go to EX_PRESS.
- EX_PRESS: examine_btn=1 for exactly HOLD_CYCLES clocks, then go to EX_SETTLE.
- EX_SETTLE:
  - examine_btn=0 for SETTLE_CYCLES clocks.
  - On the final clock, register word_data=fp_data and word_addr=addr, set word_valid=1, and go to OUT.
- OUT:
  - word_valid, word_addr and word_data are held stable until word_valid&&word_ready.
  - On handshake, word_valid=0 the next cycle.
  - If addr==last, go to DONE.
  - Otherwise addr=addr+1 mod 4096 (7777→0000 wrap) and go to EX_PRESS. There is no reload of PC, because the panel auto-increments.
  - word_ready high while word_valid=0 is ignored.
- DONE: done=1 for one cycle and busy=0 in the same cycle; go to IDLE.
- Word count is ((end_addr−start_addr) mod 4096)+1.
  - start_addr==end_addr dumps exactly 1 word.
  - end_addr<start_addr wraps through 7777 to 0000.
- Buttons are never high simultaneously, and never high in IDLE or DONE.
- sw holds start_addr for the whole dump. It changes only when a new start is accepted.
- A start arriving on the same cycle as done is ignored; a new start is accepted from IDLE only.

Test Plan:
- Reset during LPC_PRESS (load_pc_btn=1) → all outputs 0 within the same cycle; after release, state is IDLE and a start works normally.
- Single-word dump, start_addr=end_addr=0o0200, memory[0200]=0o7402, word_ready tied 1 → sw=0o0200, one load-PC pulse of 10 clocks, one examine pulse of 10 clocks, then word 0200/7402, then done pulse.
- Range 0o0200..0o0203 with known contents → 4 words with ascending addresses 0200,0201,0202,0203 and matching data, 4 examine pulses, 1 load-PC pulse.
- Backpressure: word_ready held 0 for 50 clocks on the second word → word_valid/addr/data stable throughout; no examine pulse until the handshake; the sequence then completes correctly.
- Wraparound: start_addr=0o7776, end_addr=0o0001 → 4 words at 7776,7777,0000,0001; done after the fourth handshake.
- start pulsed again while busy=1 with different addresses → ignored; the original range completes unchanged.

Source files
------------

// File: rtl/fp_memory_examiner.sv
// rtl/fp_memory_examiner.sv - front panel read-back sequencer: load PC once, examine each word, stream addr/data
module fp_memory_examiner #(
  parameter int SETUP_CYCLES  = 10,
  parameter int HOLD_CYCLES   = 10,
  parameter int SETTLE_CYCLES = 30
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [11:0] start_addr,
  input  logic [11:0] end_addr,
  output logic        busy,
  output logic        done,
  output logic [11:0] sw,
  output logic        load_pc_btn,
  output logic        examine_btn,
  input  logic [11:0] fp_data,
  output logic        word_valid,
  input  logic        word_ready,
  output logic [11:0] word_addr,
  output logic [11:0] word_data
);

  typedef enum logic [2:0] {
    IDLE, LPC_SETUP, LPC_PRESS, LPC_GAP, EX_PRESS, EX_SETTLE, OUT, DONE
  } state_t;

  localparam logic [15:0] SETUP_LAST  = 16'(SETUP_CYCLES - 1);
  localparam logic [15:0] HOLD_LAST   = 16'(HOLD_CYCLES - 1);
  localparam logic [15:0] SETTLE_LAST = 16'(SETTLE_CYCLES - 1);

  state_t      state, next_state;
  logic [15:0] cnt;
  logic [15:0] timer_last;
  logic        timed;
  logic        tick_done;
  logic [11:0] addr;
  logic [11:0] last;
  logic        handshake;

  always_comb begin
    timer_last = 16'd0;
    timed      = 1'b1;
    case (state)
      LPC_SETUP, LPC_GAP: timer_last = SETUP_LAST;
      LPC_PRESS, EX_PRESS: timer_last = HOLD_LAST;
      EX_SETTLE:           timer_last = SETTLE_LAST;
      default:             timed      = 1'b0;
    endcase
  end

  assign tick_done = timed && (cnt == timer_last);
  assign handshake = word_valid && word_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:      if (start) next_state = LPC_SETUP;
      LPC_SETUP: if (tick_done) next_state = LPC_PRESS;
      LPC_PRESS: if (tick_done) next_state = LPC_GAP;
      LPC_GAP:   if (tick_done) next_state = EX_PRESS;
      EX_PRESS:  if (tick_done) next_state = EX_SETTLE;
      EX_SETTLE: if (tick_done) next_state = OUT;
      // The panel auto-increments PC on examine, so later words skip load-PC.
      OUT:       if (handshake) next_state = (addr == last) ? DONE : EX_PRESS;
      DONE:      next_state = IDLE;
      default:   next_state = IDLE;
    endcase
  end

  // Decoded straight from state so an asynchronous reset drops the buttons at once.
  always_comb begin
    busy        = 1'b0;
    done        = 1'b0;
    load_pc_btn = 1'b0;
    examine_btn = 1'b0;
    word_valid  = 1'b0;
    case (state)
      IDLE:      ;
      DONE:      done = 1'b1;
      LPC_PRESS: begin busy = 1'b1; load_pc_btn = 1'b1; end
      EX_PRESS:  begin busy = 1'b1; examine_btn = 1'b1; end
      OUT:       begin busy = 1'b1; word_valid  = 1'b1; end
      default:   busy = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt       <= 16'd0;
      sw        <= 12'd0;
      addr      <= 12'd0;
      last      <= 12'd0;
      word_addr <= 12'd0;
      word_data <= 12'd0;
    end else begin
      cnt <= (state != next_state || !timed) ? 16'd0 : cnt + 16'd1;
      if (state == IDLE && start) begin
        sw   <= start_addr;
        addr <= start_addr;
        last <= end_addr;
      end
      if (state == EX_SETTLE && tick_done) begin
        word_addr <= addr;
        word_data <= fp_data;
      end
      if (state == OUT && handshake && addr != last)
        addr <= addr + 12'd1;
    end
  end

endmodule

// File: tb/tb_fp_memory_examiner.sv
// tb/tb_fp_memory_examiner.sv - table-driven and randomized checks of the read-back sequencer against a panel model
module tb_fp_memory_examiner;
  localparam int HOLD = 10;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [11:0] start_addr = 12'd0;
  logic [11:0] end_addr = 12'd0;
  logic        word_ready = 1'b0;
  logic [11:0] fp_data;
  logic        busy, done, load_pc_btn, examine_btn, word_valid;
  logic [11:0] sw, word_addr, word_data;

  fp_memory_examiner dut (
    .clk(clk), .rst(rst), .start(start), .start_addr(start_addr), .end_addr(end_addr),
    .busy(busy), .done(done), .sw(sw), .load_pc_btn(load_pc_btn), .examine_btn(examine_btn),
    .fp_data(fp_data), .word_valid(word_valid), .word_ready(word_ready),
    .word_addr(word_addr), .word_data(word_data)
  );

  always #5 clk = ~clk;

  // Front panel model: load-PC copies the switches, examine reads memory and bumps PC.
  logic [11:0] mem [4096];
  logic [11:0] pc = 12'd0, mb = 12'd0;
  logic        lpc_q = 1'b0, ex_q = 1'b0;
  always @(posedge clk) begin
    lpc_q <= load_pc_btn;
    ex_q  <= examine_btn;
    if (load_pc_btn && !lpc_q) pc <= sw;
    if (examine_btn && !ex_q) begin
      mb <= mem[pc];
      pc <= pc + 12'd1;
    end
  end
  assign fp_data = mb;

  int n_cmp = 0, n_fail = 0;
  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0o%0o) expected %0d (0o%0o)", name, act, act, exp, exp);
    end
  endtask

  typedef struct { logic [11:0] a; logic [11:0] d; } word_t;
  word_t got[$];
  int lpc_w = 0, ex_w = 0, lpc_pulses = 0, ex_pulses = 0, done_pulses = 0;
  int seq_bad = 0, btn_bad = 0, sw_bad = 0, stab_bad = 0;
  logic done_prev = 1'b0, prev_stall = 1'b0;
  logic [11:0] prev_a = 12'd0, prev_d = 12'd0, cur_start = 12'd0;

  always @(negedge clk) begin
    if (rst) begin
      lpc_w = 0; ex_w = 0; prev_stall = 1'b0; done_prev = 1'b0;
    end else begin
      if (load_pc_btn) lpc_w++;
      else if (lpc_w != 0) begin lpc_pulses++; if (lpc_w != HOLD) seq_bad++; lpc_w = 0; end
      if (examine_btn) ex_w++;
      else if (ex_w != 0) begin ex_pulses++; if (ex_w != HOLD) seq_bad++; ex_w = 0; end
      if ((load_pc_btn && examine_btn) || ((load_pc_btn || examine_btn) && !busy) ||
          (examine_btn && word_valid)) btn_bad++;
      if (busy && sw !== cur_start) sw_bad++;
      if (prev_stall && (!word_valid || word_addr !== prev_a || word_data !== prev_d)) stab_bad++;
      prev_stall = word_valid && !word_ready;
      prev_a = word_addr;
      prev_d = word_data;
      if (word_valid && word_ready) got.push_back('{word_addr, word_data});
      if (done) begin done_pulses++; if (done_prev || busy) seq_bad++; end
      done_prev = done;
    end
  end

  int ready_mode = 0, stall_cnt = 0;
  always @(posedge clk) begin
    #1;
    case (ready_mode)
      1: word_ready = 1'($urandom_range(0, 1));
      2: if (got.size() == 1 && word_valid && stall_cnt < 50) begin
           word_ready = 1'b0;
           stall_cnt++;
         end else word_ready = 1'b1;
      default: word_ready = 1'b1;
    endcase
  end

  // extra: 0 none, 1 second start while busy, 2 start coinciding with done
  task automatic run_dump(input logic [11:0] s, input logic [11:0] e, input int mode,
                          input int extra, input int exp_cnt, input int exp_d0, input string tag);
    word_t exp_q[$];
    int cnt, cyc, n;
    logic [11:0] a;
    cnt = ((((int'(e) - int'(s)) % 4096) + 4096) % 4096) + 1;
    for (int i = 0; i < cnt; i++) begin
      a = 12'((int'(s) + i) % 4096);
      exp_q.push_back('{a, mem[a]});
    end
    got.delete();
    lpc_pulses = 0; ex_pulses = 0; done_pulses = 0;
    seq_bad = 0; btn_bad = 0; sw_bad = 0; stab_bad = 0;
    ready_mode = mode; stall_cnt = 0; cur_start = s;
    @(posedge clk); #1;
    start = 1'b1; start_addr = s; end_addr = e;
    @(posedge clk); #1;
    start = 1'b0; start_addr = 12'($urandom); end_addr = 12'($urandom);
    check($sformatf("%s busy after start", tag), int'(busy), 1);
    check($sformatf("%s sw", tag), int'(sw), int'(s));
    if (extra == 1) begin
      repeat (100) @(posedge clk);
      #1; start = 1'b1; start_addr = s + 12'd100; end_addr = s + 12'd3;
      @(posedge clk); #1; start = 1'b0;
    end
    cyc = 0;
    while (!done && cyc < 300 + cnt * 250) begin @(negedge clk); cyc++; end
    check($sformatf("%s done seen", tag), int'(done), 1);
    if (extra == 2) begin
      start = 1'b1; start_addr = s ^ 12'd1; end_addr = s ^ 12'd1;
      @(posedge clk); #1; start = 1'b0;
      repeat (3) @(negedge clk);
      check($sformatf("%s start on done ignored", tag), int'(busy), 0);
    end
    repeat (3) @(negedge clk);
    check($sformatf("%s word count", tag), got.size(), exp_cnt);
    n = (got.size() < cnt) ? got.size() : cnt;
    for (int i = 0; i < n; i++) begin
      check($sformatf("%s w%0d addr", tag, i), int'(got[i].a), int'(exp_q[i].a));
      check($sformatf("%s w%0d data", tag, i), int'(got[i].d), int'(exp_q[i].d));
    end
    if (exp_d0 >= 0 && got.size() > 0) check($sformatf("%s first data", tag), int'(got[0].d), exp_d0);
    check($sformatf("%s load-pc pulses", tag), lpc_pulses, 1);
    check($sformatf("%s examine pulses", tag), ex_pulses, cnt);
    check($sformatf("%s done pulses", tag), done_pulses, 1);
    check($sformatf("%s pulse widths", tag), seq_bad, 0);
    check($sformatf("%s button rules", tag), btn_bad, 0);
    check($sformatf("%s sw held", tag), sw_bad, 0);
    check($sformatf("%s word stable", tag), stab_bad, 0);
    check($sformatf("%s idle after", tag), int'(busy), 0);
    if (mode == 2 && cnt >= 2) check($sformatf("%s stall length", tag), stall_cnt, 50);
  endtask

  typedef struct {
    logic [11:0] s; logic [11:0] e; int mode; int extra; int exp_cnt; int exp_d0;
  } vec_t;
  vec_t vecs[6];

  initial begin
    int cyc, len;
    logic [11:0] rs;
    for (int i = 0; i < 4096; i++) mem[i] = 12'($urandom);
    mem[12'o0200] = 12'o7402; mem[12'o0201] = 12'o1234;
    mem[12'o0202] = 12'o5670; mem[12'o0203] = 12'o0017;
    vecs[0] = '{12'o0200, 12'o0200, 0, 0, 1, 'o7402};
    vecs[1] = '{12'o0200, 12'o0203, 0, 0, 4, 'o7402};
    vecs[2] = '{12'o0200, 12'o0203, 2, 0, 4, 'o7402};
    vecs[3] = '{12'o7776, 12'o0001, 0, 0, 4, -1};
    vecs[4] = '{12'o0100, 12'o0103, 1, 1, 4, -1};
    vecs[5] = '{12'o0005, 12'o0005, 0, 2, 1, -1};

    repeat (3) @(negedge clk);
    check("reset busy", int'(busy), 0);
    check("reset buttons", int'({load_pc_btn, examine_btn}), 0);
    check("reset word_valid", int'(word_valid), 0);
    check("reset sw/addr/data", int'({sw, word_addr, word_data}), 0);
    rst = 1'b0;

    // Abort during the load-PC press.
    cur_start = 12'o1234;
    @(posedge clk); #1;
    start = 1'b1; start_addr = 12'o1234; end_addr = 12'o1240;
    @(posedge clk); #1; start = 1'b0;
    cyc = 0;
    while (!load_pc_btn && cyc < 100) begin @(negedge clk); cyc++; end
    check("abort saw load-pc", int'(load_pc_btn), 1);
    #2 rst = 1'b1;
    #1;
    check("abort buttons", int'({load_pc_btn, examine_btn}), 0);
    check("abort busy/done/valid", int'({busy, done, word_valid}), 0);
    check("abort sw/addr/data", int'({sw, word_addr, word_data}), 0);
    check("abort no word", got.size(), 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    foreach (vecs[i])
      run_dump(vecs[i].s, vecs[i].e, vecs[i].mode, vecs[i].extra,
               vecs[i].exp_cnt, vecs[i].exp_d0, $sformatf("vec%0d", i));

    for (int k = 0; k < 8; k++) begin
      rs  = (k == 0) ? 12'o7770 : 12'($urandom);
      len = $urandom_range(1, 12);
      run_dump(rs, rs + 12'(len - 1), 1, 0, len, -1, $sformatf("rnd%0d", k));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
